// File: rtl/fpmul_result_sink_if.sv
// Result-sink bundle: multiplier-side operand/product signals plus the
// downstream valid/ready result port and status flags.
interface fpmul_result_sink_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             data_en;
  logic             end_in;
  logic [WIDTH-1:0] data_z;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [15:0]      out_idx;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             done;

  modport master (
    output data_en, end_in, data_z, out_ready,
    input  out_valid, out_data, out_idx, count, overflow, done
  );

  modport slave (
    input  data_en, end_in, data_z, out_ready,
    output out_valid, out_data, out_idx, count, overflow, done
  );
endinterface

// File: rtl/fpmul_result_sink.sv
// Receive end of a valid-less fixed-latency multiplier: rebuilds result
// validity with a tag pipeline, queues indexed products, tracks end of stream.
module fpmul_result_sink #(
  parameter int LATENCY = 4,
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fpmul_result_sink_if.slave sink_if
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] last_q, last_d;
  logic               tag_en;
  logic               res_v, res_last;

  logic [WIDTH-1:0]   data_mem [DEPTH];
  logic [15:0]        idx_mem  [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic [15:0]        idx_q;
  logic               ovf_q;
  logic               full, push, pop, drop;

  // Tags are only accepted while the stream is open (IDLE or RUN).
  assign tag_en = sink_if.data_en & ((state_q == S_IDLE) | (state_q == S_RUN));

  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign vld_d[gi]  = tag_en;
        assign last_d[gi] = tag_en & sink_if.end_in;
      end else begin : g_body
        assign vld_d[gi]  = vld_q[gi-1];
        assign last_d[gi] = last_q[gi-1];
      end
    end
  endgenerate

  assign res_v    = vld_q[LATENCY-1];
  assign res_last = last_q[LATENCY-1];

  assign full = (count_q == CW'(DEPTH));
  assign pop  = (count_q != '0) & sink_if.out_ready;
  assign push = res_v & (~full | pop);
  assign drop = res_v & full & ~pop;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // DONE is decided on post-edge occupancy so it rises right after the last pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sink_if.data_en) state_d = sink_if.end_in ? S_DRAIN : S_RUN;
      S_RUN:   if (sink_if.data_en & sink_if.end_in) state_d = S_DRAIN;
      S_DRAIN: if ((vld_d == '0) && (count_d == '0)) state_d = S_DONE;
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      vld_q    <= '0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (res_v) idx_q <= idx_q + 16'd1;
      if (drop)  ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr_q] <= sink_if.data_z;
      idx_mem[wr_ptr_q]  <= idx_q;
    end
  end

  assign sink_if.out_valid = (count_q != '0);
  assign sink_if.out_data  = data_mem[rd_ptr_q];
  assign sink_if.out_idx   = idx_mem[rd_ptr_q];
  assign sink_if.count     = count_q;
  assign sink_if.overflow  = ovf_q;
  assign sink_if.done      = (state_q == S_DONE);

  a_last_implies_valid: assert property (@(posedge clk_i) disable iff (rst_i) res_last |-> res_v);
endmodule

// File: tb/tb_fpmul_result_sink.sv
// Randomized and directed bench for fpmul_result_sink against a queue-based
// reference model of scheduled arrivals, FIFO contents and stream state.
module tb_fpmul_result_sink;
  localparam int LATENCY = 4;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 8;

  typedef struct {
    logic [31:0] d;
    logic [15:0] idx;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: arrival edges of in-flight operands, queued entries, stream phase.
  int          edge_n = 0;
  int          arrivals[$];
  ent_t        m_fifo[$];
  logic [15:0] m_idx = '0;
  bit          m_ovf = 1'b0;
  int          m_state = 0;

  fpmul_result_sink_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fpmul_result_sink #(.LATENCY(LATENCY), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .sink_if (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_edge(input logic r, input logic en, input logic en_end,
                            input logic rdy, input logic [31:0] z);
    bit res_v, do_pop;
    if (r) begin
      arrivals.delete();
      m_fifo.delete();
      m_idx   = '0;
      m_ovf   = 1'b0;
      m_state = 0;
      edge_n++;
      return;
    end
    res_v = (arrivals.size() > 0) && (arrivals[0] == edge_n);
    if (res_v) void'(arrivals.pop_front());
    do_pop = (m_fifo.size() > 0) && rdy;
    if (do_pop) void'(m_fifo.pop_front());
    if (res_v) begin
      if (m_fifo.size() < DEPTH) m_fifo.push_back('{d: z, idx: m_idx});
      else m_ovf = 1'b1;
      m_idx = m_idx + 16'd1;
    end
    if (en && m_state < 2) arrivals.push_back(edge_n + LATENCY);
    case (m_state)
      0: if (en) m_state = en_end ? 2 : 1;
      1: if (en && en_end) m_state = 2;
      2: if (arrivals.size() == 0 && m_fifo.size() == 0) m_state = 3;
      default: ;
    endcase
    edge_n++;
  endtask

  task automatic compare();
    check("out_valid", 32'(bus.out_valid), 32'(m_fifo.size() != 0));
    check("count", 32'(bus.count), 32'(m_fifo.size()));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    check("done", 32'(bus.done), 32'(m_state == 3));
    if (m_fifo.size() > 0) begin
      check("out_data", bus.out_data, m_fifo[0].d);
      check("out_idx", 32'(bus.out_idx), 32'(m_fifo[0].idx));
    end
  endtask

  task automatic step(input logic r, input logic en, input logic en_end,
                      input logic rdy, input logic [31:0] z);
    rst           = r;
    bus.data_en   = en;
    bus.end_in    = en_end;
    bus.out_ready = rdy;
    bus.data_z    = z;
    @(posedge clk);
    model_edge(r, en, en_end, rdy, z);
    #1;
    compare();
    $display("edge=%0d rst=%0b en=%0b end=%0b rdy=%0b -> valid=%0b idx=%0d data=%h count=%0d ovf=%0b done=%0b",
             edge_n - 1, r, en, en_end, rdy, bus.out_valid, bus.out_idx, bus.out_data,
             bus.count, bus.overflow, bus.done);
  endtask

  initial begin
    bus.data_en   = 1'b0;
    bus.end_in    = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_z    = '0;

    // Reset state.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_count", 32'(bus.count), 32'd0);

    // Single operand: product 1.5^2 presented at edge 4.
    for (int i = 0; i < 9; i++) begin
      step(0, i == 0, 0, 1, (i == 4) ? 32'h40100000 : $urandom);
      if (i == 4) begin
        check("single_valid", 32'(bus.out_valid), 32'd1);
        check("single_data", bus.out_data, 32'h40100000);
        check("single_idx", 32'(bus.out_idx), 32'd0);
      end
      if (i == 5) check("single_count0", 32'(bus.count), 32'd0);
    end

    // Streaming: 20 operands, ready held high.
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 28; i++) begin
      step(0, i < 20, 0, 1, $urandom);
      check("stream_count_le1", 32'(bus.count <= 1), 32'd1);
      if (i >= 4 && i < 24) check("stream_idx", 32'(bus.out_idx), 32'(i - 4));
    end

    // Backpressure overflow: 10 operands, ready low, then drain.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, i < 10, 0, 0, $urandom);
      if (i == 11) check("bp_ovf_at_9th", 32'(bus.overflow), 32'd0);
      if (i == 12) check("bp_ovf_set", 32'(bus.overflow), 32'd1);
    end
    check("bp_count_full", 32'(bus.count), 32'd8);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, $urandom);

    // Full FIFO with an arriving result and a pop at the same edge.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      step(0, i < 9, 0, i == 12, $urandom);
      if (i == 12) begin
        check("fullpp_count", 32'(bus.count), 32'd8);
        check("fullpp_ovf", 32'(bus.overflow), 32'd0);
      end
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, $urandom);

    // End of stream, then a late operand that must be ignored.
    step(1, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, (i < 3) || (i == 12), i == 2, 1, $urandom);
      if (i == 6) check("eos_done_early", 32'(bus.done), 32'd0);
      if (i == 7) check("eos_done", 32'(bus.done), 32'd1);
      if (i >= 12) check("eos_no_output", 32'(bus.out_valid), 32'd0);
    end

    // Reset with 2 queued entries and 4 operands in flight.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, $urandom);
    check("midrst_pre_count", 32'(bus.count), 32'd2);
    step(1, 0, 0, 0, 0);
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_count", 32'(bus.count), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step(0, i == 6, 0, 0, $urandom);
      if (i < 10) check("midrst_no_ghost", 32'(bus.out_valid), 32'd0);
      if (i == 10) check("midrst_idx0", 32'(bus.out_idx), 32'd0);
    end

    // Randomized traffic with occasional end markers and resets.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 50, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
